// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the MEM-stage load/store engine.
package rv32_mem_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned BE_W    = XLEN / 8;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned FUNC3_W = 3;
  localparam int unsigned CNT_W   = 16;

  localparam logic [FUNC3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNC3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNC3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNC3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNC3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Payload presented to data memory while a request is outstanding.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dmem_req_t;

endpackage : rv32_mem_pkg

// File: rtl/store_lane_align.sv
// Byte-lane steering and alignment check for a single memory access.
module store_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [FUNC3_W-1:0] func3_i,
  input  logic [OFF_W-1:0]   off_i,
  input  logic [XLEN-1:0]    wd_i,
  output logic [BE_W-1:0]    be_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic               misalign_o
);

  // Size decode; anything that is not a byte or halfword behaves as a word.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wd_i;
    misalign_o = 1'b0;
    case (func3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wd_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{wd_i[15:0]}};
        misalign_o = off_i[0];
      end
      default: begin
        misalign_o = (off_i != 2'b00);
      end
    endcase
  end

endmodule : store_lane_align

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues req/ack transactions to data memory and
// stalls the pipeline until each completes.
module mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [XLEN-1:0]    MEM_ALU_RESULT,
  input  logic [XLEN-1:0]    MEM_WRITE_DATA,
  input  logic               MEM_READ,
  input  logic               MEM_WRITE,
  input  logic [FUNC3_W-1:0] MEM_FUNC3,
  output logic [XLEN-1:0]    MEM_READ_DATA,
  output logic               MEM_STALL,
  output logic               MEM_MISALIGN,
  output logic               MEM_FAULT,
  output logic               DMEM_REQ,
  output logic               DMEM_WE,
  output logic [XLEN-1:0]    DMEM_ADDR,
  output logic [XLEN-1:0]    DMEM_WDATA,
  output logic [BE_W-1:0]    DMEM_BE,
  input  logic               DMEM_ACK,
  input  logic [XLEN-1:0]    DMEM_RDATA
);

  state_e            state_q, state_d;
  dmem_req_t         bus_q, bus_d;
  logic              req_q, req_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [BE_W-1:0]   lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic              lane_misalign;
  logic              mem_op;
  logic              misalign;
  logic              access;

  store_lane_align u_lane (
    .func3_i    (MEM_FUNC3),
    .off_i      (MEM_ALU_RESULT[1:0]),
    .wd_i       (MEM_WRITE_DATA),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_misalign)
  );

  // Request qualification from the instruction currently in MEM.
  always_comb begin
    mem_op   = MEM_READ | MEM_WRITE;
    misalign = mem_op & lane_misalign;
    access   = mem_op & ~lane_misalign;
  end

  // Next-state, bus payload, timeout counter and load-data capture.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    req_d   = req_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          bus_d.we    = MEM_WRITE;
          bus_d.addr  = {MEM_ALU_RESULT[XLEN-1:2], 2'b00};
          bus_d.wdata = lane_wdata;
          bus_d.be    = MEM_WRITE ? lane_be : 4'b1111;
          off_d       = MEM_ALU_RESULT[1:0];
          req_d       = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end else if (misalign) begin
          rdata_d = '0;
        end
      end
      BUSY: begin
        if (DMEM_ACK) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
          if (!bus_q.we) begin
            rdata_d = DMEM_RDATA >> {off_q, 3'b000};
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          rdata_d = '0;
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and payload registers; reset drops any outstanding request at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      bus_q   <= '0;
      req_q   <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      req_q   <= req_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Output mapping; a misaligned op in MEM reads as zero in its own cycle.
  always_comb begin
    MEM_STALL     = ((state_q == IDLE) & access) | (state_q == BUSY);
    MEM_MISALIGN  = misalign;
    MEM_READ_DATA = ((state_q == IDLE) & misalign) ? '0 : rdata_q;
    MEM_FAULT     = fault_q;
    DMEM_REQ      = req_q;
    DMEM_WE       = bus_q.we;
    DMEM_ADDR     = bus_q.addr;
    DMEM_WDATA    = bus_q.wdata;
    DMEM_BE       = bus_q.be;
  end

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural access model.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] MEM_ALU_RESULT = '0;
  logic [31:0] MEM_WRITE_DATA = '0;
  logic        MEM_READ = 1'b0;
  logic        MEM_WRITE = 1'b0;
  logic [2:0]  MEM_FUNC3 = '0;
  logic [31:0] MEM_READ_DATA;
  logic        MEM_STALL, MEM_MISALIGN, MEM_FAULT;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic        DMEM_ACK = 1'b0;
  logic [31:0] DMEM_RDATA = '0;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] exp_rd = '0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_FUNC3(MEM_FUNC3),
    .MEM_READ_DATA(MEM_READ_DATA), .MEM_STALL(MEM_STALL),
    .MEM_MISALIGN(MEM_MISALIGN), .MEM_FAULT(MEM_FAULT),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE),
    .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA)
  );

  // Access size in bytes from FUNC3; unsupported encodings are words.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Bytes touched: sz consecutive lanes starting at the byte offset.
  function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] b;
    int sz, off;
    sz = size_of(f3);
    off = int'(addr[1:0]);
    b = '0;
    if (!wr) return 4'b1111;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) b[i] = 1'b1;
    return b;
  endfunction

  // Each lane carries the store byte that lands there for any aligned offset.
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int sz;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
    return w;
  endfunction

  task automatic run_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int dly);
    bit mis, tmo;
    mis = (int'(addr[1:0]) % size_of(f3)) != 0;
    tmo = !(dly >= 0 && dly < int'(TO));
    @(posedge CLK); #1;
    MEM_READ = rd; MEM_WRITE = wr; MEM_FUNC3 = f3;
    MEM_ALU_RESULT = addr; MEM_WRITE_DATA = wd;
    #1;
    n_chk++; if (MEM_MISALIGN !== mis) $display("FAIL %s misalign: got %b exp %b", nm, MEM_MISALIGN, mis); else n_pass++;
    n_chk++; if (MEM_STALL !== !mis) $display("FAIL %s stall_issue: got %b exp %b", nm, MEM_STALL, !mis); else n_pass++;
    n_chk++; if (DMEM_REQ !== 1'b0) $display("FAIL %s req_idle: got %b exp 0", nm, DMEM_REQ); else n_pass++;
    if (mis) begin
      exp_rd = '0;
      n_chk++; if (MEM_READ_DATA !== 32'h0) $display("FAIL %s mis_rdata: got %h exp 0", nm, MEM_READ_DATA); else n_pass++;
      @(posedge CLK); #1;
      n_chk++; if (DMEM_REQ !== 1'b0) $display("FAIL %s mis_noreq: got %b exp 0", nm, DMEM_REQ); else n_pass++;
      MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    n_chk++; if (DMEM_REQ !== 1'b1) $display("FAIL %s req_busy: got %b exp 1", nm, DMEM_REQ); else n_pass++;
    n_chk++; if (DMEM_WE !== wr) $display("FAIL %s we: got %b exp %b", nm, DMEM_WE, wr); else n_pass++;
    n_chk++; if (DMEM_ADDR !== {addr[31:2], 2'b00}) $display("FAIL %s addr: got %h exp %h", nm, DMEM_ADDR, {addr[31:2], 2'b00}); else n_pass++;
    n_chk++; if (DMEM_BE !== m_be(wr, f3, addr)) $display("FAIL %s be: got %b exp %b", nm, DMEM_BE, m_be(wr, f3, addr)); else n_pass++;
    if (wr) begin
      n_chk++; if (DMEM_WDATA !== m_wdata(f3, wd)) $display("FAIL %s wdata: got %h exp %h", nm, DMEM_WDATA, m_wdata(f3, wd)); else n_pass++;
    end
    for (int k = 0; k < int'(TO) + 2; k++) begin
      if (k == dly) begin
        DMEM_ACK = 1'b1; DMEM_RDATA = rdata;
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0; DMEM_RDATA = $urandom;
        break;
      end
      @(posedge CLK); #1;
      if (k == int'(TO) - 1) break;
      n_chk++; if ({DMEM_REQ, MEM_STALL} !== 2'b11) $display("FAIL %s busy_hold: got req/stall %b exp 11", nm, {DMEM_REQ, MEM_STALL}); else n_pass++;
    end
    if (tmo) exp_rd = '0;
    else if (rd) exp_rd = rdata >> (8 * int'(addr[1:0]));
    n_chk++; if (DMEM_REQ !== 1'b0) $display("FAIL %s req_done: got %b exp 0", nm, DMEM_REQ); else n_pass++;
    n_chk++; if (MEM_STALL !== 1'b0) $display("FAIL %s stall_done: got %b exp 0", nm, MEM_STALL); else n_pass++;
    n_chk++; if (MEM_FAULT !== tmo) $display("FAIL %s fault: got %b exp %b", nm, MEM_FAULT, tmo); else n_pass++;
    n_chk++; if (MEM_READ_DATA !== exp_rd) $display("FAIL %s rdata: got %h exp %h", nm, MEM_READ_DATA, exp_rd); else n_pass++;
  endtask

  task automatic idle_cycle(input string nm);
    @(posedge CLK); #1;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    #1;
    n_chk++; if ({DMEM_REQ, MEM_STALL, MEM_FAULT} !== 3'b000) $display("FAIL %s idle: got req/stall/fault %b exp 000", nm, {DMEM_REQ, MEM_STALL, MEM_FAULT}); else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if ({DMEM_REQ, DMEM_WE, MEM_FAULT, MEM_STALL} !== 4'b0000) $display("FAIL reset_ctrl: got %b exp 0000", {DMEM_REQ, DMEM_WE, MEM_FAULT, MEM_STALL}); else n_pass++;
    n_chk++; if ({DMEM_ADDR, DMEM_WDATA, DMEM_BE, MEM_READ_DATA} !== 100'h0) $display("FAIL reset_data: got %h %h %b %h exp zeros", DMEM_ADDR, DMEM_WDATA, DMEM_BE, MEM_READ_DATA); else n_pass++;
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  task automatic test_directed();
    run_access("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    n_chk++; if (MEM_READ_DATA !== 32'hDEADBEEF) $display("FAIL lw_const: got %h exp deadbeef", MEM_READ_DATA); else n_pass++;
    idle_cycle("lw");
    run_access("sb", 1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0);
    n_chk++; if (MEM_READ_DATA !== 32'hDEADBEEF) $display("FAIL sb_keeps_rdata: got %h exp deadbeef", MEM_READ_DATA); else n_pass++;
    idle_cycle("sb");
    run_access("lh", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2);
    n_chk++; if (MEM_READ_DATA !== 32'h00008001) $display("FAIL lh_const: got %h exp 00008001", MEM_READ_DATA); else n_pass++;
    idle_cycle("lh");
    run_access("sh", 1'b0, 1'b1, 3'b001, 32'h42, 32'h1234BEEF, 32'h0, 0);
    idle_cycle("sh");
    run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    idle_cycle("lw_mis");
  endtask

  task automatic test_timeout();
    run_access("lb_seed", 1'b1, 1'b0, 3'b000, 32'h7, 32'h0, 32'h5A000000, 0);
    idle_cycle("lb_seed");
    run_access("timeout", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
    idle_cycle("timeout");
  endtask

  task automatic test_ack_idle();
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hCAFEF00D;
    @(posedge CLK); #1;
    DMEM_ACK = 1'b0;
    n_chk++; if (MEM_READ_DATA !== exp_rd) $display("FAIL ack_idle_rdata: got %h exp %h", MEM_READ_DATA, exp_rd); else n_pass++;
    n_chk++; if ({DMEM_REQ, MEM_STALL, MEM_FAULT} !== 3'b000) $display("FAIL ack_idle_ctrl: got %b exp 000", {DMEM_REQ, MEM_STALL, MEM_FAULT}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_access("b2b_lbu", 1'b1, 1'b0, 3'b100, 32'h1001, 32'h0, 32'h0000F700, 0);
    run_access("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h2000, 32'h01020304, 32'h0, 1);
    run_access("b2b_lhu", 1'b1, 1'b0, 3'b101, 32'h3002, 32'h0, 32'hABCD0000, 3);
    idle_cycle("b2b");
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    MEM_READ = 1'b1; MEM_FUNC3 = 3'b010; MEM_ALU_RESULT = 32'h400;
    @(posedge CLK); #1;
    n_chk++; if (DMEM_REQ !== 1'b1) $display("FAIL rst_mid_pre: got %b exp 1", DMEM_REQ); else n_pass++;
    RST_N = 1'b0;
    #1;
    n_chk++; if (DMEM_REQ !== 1'b0) $display("FAIL rst_mid_drop: got %b exp 0", DMEM_REQ); else n_pass++;
    MEM_READ = 1'b0;
    exp_rd = '0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h13572468;
    @(posedge CLK); #1;
    DMEM_ACK = 1'b0;
    n_chk++; if ({DMEM_REQ, MEM_STALL, MEM_FAULT} !== 3'b000) $display("FAIL rst_mid_ack: got %b exp 000", {DMEM_REQ, MEM_STALL, MEM_FAULT}); else n_pass++;
    n_chk++; if (MEM_READ_DATA !== 32'h0) $display("FAIL rst_mid_rdata: got %h exp 0", MEM_READ_DATA); else n_pass++;
    run_access("post_rst", 1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h600DD00D, 0);
    idle_cycle("post_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic rd;
      logic [2:0] f3;
      int r, dly;
      rd = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      dly = (r == 9) ? -1 : r % 4;
      run_access("rand", rd, !rd, f3, $urandom, $urandom, $urandom, dly);
      if ($urandom_range(0, 1) == 1) idle_cycle("rand");
    end
    idle_cycle("rand_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ack_idle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish exp finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_access_unit
